fir_lid_arbiter: RTL and testbench
==================================

FIR_LID_ARBITER -- requirements
Module: fir_lid_arbiter

Interface
REQ-001 Parameter DATA_W, 16, width of each data word.
REQ-002 Parameter BURST_LEN, 4, maximum consecutive beats granted to one requester while the other waits; legal range >= 1.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_req0_data  input  DATA_W  signed sample from requester 0.
REQ-006 i_req0_valid  input  1  requester 0 data is valid.
REQ-007 o_req0_stop  output  1  backpressure to requester 0; no transfer while high.
REQ-008 i_req1_data  input  DATA_W  signed sample from requester 1.
REQ-009 i_req1_valid  input  1  requester 1 data is valid.
REQ-010 o_req1_stop  output  1  backpressure to requester 1.
REQ-011 o_data  output  DATA_W  registered sample to the FIR cascade input.
REQ-012 o_valid  output  1  o_data is valid.
REQ-013 o_src  output  1  index of the requester that supplied o_data.
REQ-014 i_stop  input  1  backpressure from the FIR cascade.

Function
REQ-015 Output transfer SHALL occur when o_valid=1 and i_stop=0. Requester k transfer SHALL occur when i_reqk_valid=1 and o_reqk_stop=0.
REQ-016 load_en SHALL be defined as (o_valid=0 or i_stop=0); the output register loads only when load_en=1.
REQ-017 With load_en=0: o_req0_stop=o_req1_stop=1, and o_data, o_valid, o_src, state, last and cnt SHALL all hold.
REQ-018 With load_en=1, sel SHALL be chosen combinationally in the same cycle; o_reqsel_stop=0 and the other stop=1. With no valid request, both stops=1.
REQ-019 The arbiter SHALL have the states IDLE, OWN0 and OWN1, plus a register last (1 bit) and a counter cnt (0..BURST_LEN, width clog2(BURST_LEN+1)).
REQ-020 Selection with load_en=1 and exactly one requester valid: sel = that requester.
REQ-021 Selection with both valid, in IDLE: sel = !last.
REQ-022 Selection with both valid, in OWNk: sel = k if cnt < BURST_LEN, otherwise sel = the other requester.
REQ-023 Update on accept from sel (state OWNsel): cnt <= cnt+1, saturating at BURST_LEN.
REQ-024 Update on accept from sel (any other state): state <= OWNsel, cnt <= 1.
REQ-025 On every accept: last <= sel, o_data <= i_reqsel_data, o_src <= sel, o_valid <= 1.
REQ-026 With load_en=1 and no requester valid: state <= IDLE, cnt <= 0, o_valid <= 0; o_data, o_src and last hold.
REQ-027 Simultaneous output drain and input accept SHALL sustain one beat per cycle with no bubble; throughput is 1 beat/cycle.
REQ-028 Latency SHALL be 1 cycle from input accept to o_valid=1.
REQ-029 Data SHALL pass unmodified, with no arithmetic; no beat is dropped or duplicated; per-requester order is preserved.
REQ-030 The stop outputs SHALL depend combinationally only on i_stop, o_valid, the valid inputs and registered state; there is no combinational path from the data inputs.

Reset
REQ-031 While reset=1 at a rising edge: o_valid=0, o_data=0, o_src=0, state=IDLE, last=1, cnt=0.
REQ-032 During the reset cycle, both stops SHALL be 1 and no input is accepted.
REQ-033 Reset asserted mid-burst SHALL discard the held output beat and the arbitration history, with no partial update.

Verification
REQ-034 Both requesters continuously valid (req0 = 0,1,2..., req1 = 100,101,...), i_stop=0, BURST_LEN=4 -> o_src pattern 0,0,0,0,1,1,1,1,0... with o_data 0,1,2,3,100,101,102,103,4..., one beat per cycle.
REQ-035 Only req1 valid, data 5..9 -> o_data 5..9 on consecutive cycles, o_src=1; o_req0_stop=1 throughout.
REQ-036 i_stop held high for 3 cycles with o_valid=1, o_data=7 -> o_data stays 7, both o_reqk_stop=1, no input consumed; transfer resumes on the cycle after i_stop drops.
REQ-037 Random i_stop and random valid toggling on both requesters over 200 beats each -> per-source output streams equal the input streams exactly, in order, with no loss or duplication.
REQ-038 Tie after an idle gap when last=0 -> req1 granted first; after reset with an immediate tie -> req0 granted first.
REQ-039 Reset asserted for 1 cycle mid-burst (o_valid=1, cnt=2) -> next cycle o_valid=0, state IDLE; the following tie grants req0.

Source files
------------

// File: rtl/fir_lid_arbiter.sv
// fir_lid_arbiter: two-requester burst arbiter feeding a registered FIR cascade input
module fir_lid_arbiter #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_req0_data,
  input  logic              i_req0_valid,
  output logic              o_req0_stop,
  input  logic [DATA_W-1:0] i_req1_data,
  input  logic              i_req1_valid,
  output logic              o_req1_stop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_src,
  input  logic              i_stop
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t            state_q, state_d, own;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, src_q, src_d;
  logic              load_en, any_valid, accept, sel;
  // Grant selection, backpressure and next-state; stops never see the data inputs
  always_comb begin
    load_en   = !valid_q || !i_stop;
    any_valid = i_req0_valid || i_req1_valid;
    accept    = load_en && any_valid && !reset;
    sel       = (i_req0_valid && i_req1_valid)
              ? ((state_q == IDLE) ? !last_q
                : ((cnt_q < CNT_MAX) ? (state_q == OWN1) : (state_q == OWN0)))
              : i_req1_valid;
    o_req0_stop = !(accept && !sel);
    o_req1_stop = !(accept && sel);
    own     = sel ? OWN1 : OWN0;
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    valid_d = valid_q;
    src_d   = src_q;
    if (accept) begin
      if (state_q == own) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      end else begin
        state_d = own;
        cnt_d   = CW'(1);
      end
      last_d  = sel;
      data_d  = sel ? i_req1_data : i_req0_data;
      src_d   = sel;
      valid_d = 1'b1;
    end else if (load_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end
  end
  // State, history and output register; reset drops any held beat and history
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
    end
  end
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_src   = src_q;
endmodule

// File: tb/tb_fir_lid_arbiter.sv
// tb_fir_lid_arbiter: directed and random checks of the arbiter against a behavioural model
module tb_fir_lid_arbiter;
  localparam int DW = 16;
  localparam int BL = 4;
  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] i_req0_data, i_req1_data, o_data;
  logic          i_req0_valid, i_req1_valid, i_stop;
  logic          o_req0_stop, o_req1_stop, o_valid, o_src;
  int checks = 0;
  int errors = 0;
  logic          m_valid = 1'b0;
  logic          m_src = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            m_owner = -1;
  int            m_run = 0;
  int            m_last = 1;
  int            acc_k;
  int sent0[$], sent1[$], rx0[$], rx1[$];

  fir_lid_arbiter #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clock(clock), .reset(reset),
    .i_req0_data(i_req0_data), .i_req0_valid(i_req0_valid), .o_req0_stop(o_req0_stop),
    .i_req1_data(i_req1_data), .i_req1_valid(i_req1_valid), .o_req1_stop(o_req1_stop),
    .o_data(o_data), .o_valid(o_valid), .o_src(o_src), .i_stop(i_stop)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check stops before the edge, step the model, check registered outputs after it
  task automatic cyc();
    int g;
    logic ld, acc, pv, ps;
    logic [DW-1:0] pd, gd;
    #3;
    ld = !m_valid || !i_stop;
    g = -1;
    if (i_req0_valid && !i_req1_valid) g = 0;
    else if (i_req1_valid && !i_req0_valid) g = 1;
    else if (i_req0_valid && i_req1_valid)
      g = (m_owner < 0) ? 1 - m_last : ((m_run < BL) ? m_owner : 1 - m_owner);
    acc = !reset && ld && (g >= 0);
    chk("stop0", 32'(o_req0_stop), 32'(!(acc && g == 0)));
    chk("stop1", 32'(o_req1_stop), 32'(!(acc && g == 1)));
    gd = (g == 1) ? i_req1_data : i_req0_data;
    pv = o_valid; pd = o_data; ps = o_src;
    @(posedge clock);
    if (pv && !i_stop) begin
      if (ps) rx1.push_back(int'(pd)); else rx0.push_back(int'(pd));
    end
    acc_k = acc ? g : -1;
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_owner = -1; m_run = 0; m_last = 1;
    end else if (acc) begin
      if (m_owner == g) m_run = (m_run < BL) ? m_run + 1 : BL;
      else begin m_owner = g; m_run = 1; end
      m_last = g; m_data = gd; m_src = (g == 1); m_valid = 1'b1;
      if (g == 1) sent1.push_back(int'(gd)); else sent0.push_back(int'(gd));
    end else if (ld) begin
      m_owner = -1; m_run = 0; m_valid = 1'b0;
    end
    #1;
    chk("o_valid", 32'(o_valid), 32'(m_valid));
    chk("o_data", 32'(o_data), 32'(m_data));
    chk("o_src", 32'(o_src), 32'(m_src));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic idle_in();
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_stop = 1'b0;
    i_req0_data = '0; i_req1_data = '0;
  endtask

  initial begin
    int n0, n1, c0, c1, bnd;
    idle_in();
    reset = 1'b1;
    // reset state
    cyc();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_src", 32'(o_src), 32'd0);
    reset = 1'b0;
    // both requesters continuously valid: bursts of BL alternate
    n0 = 0; n1 = 100;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_req0_data = DW'(n0); i_req1_data = DW'(n1);
      cyc();
      if (acc_k == 0) n0++;
      if (acc_k == 1) n1++;
      chk("burst_src", 32'(o_src), 32'((i / BL) % 2));
      chk("burst_data", 32'(o_data),
          32'(((i / BL) % 2 ? 100 : 0) + BL * (i / (2 * BL)) + i % BL));
    end
    // only req1 valid
    idle_in();
    do_reset();
    i_req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_req1_data = DW'(5 + i);
      cyc();
      chk("r1_data", 32'(o_data), 32'(5 + i));
      chk("r1_src", 32'(o_src), 32'd1);
      chk("r1_stop0", 32'(o_req0_stop), 32'd1);
    end
    // downstream stall holds the beat and blocks both inputs
    idle_in();
    do_reset();
    i_req0_valid = 1'b1; i_req0_data = DW'(7);
    cyc();
    i_req0_data = DW'(8); i_stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_data", 32'(o_data), 32'd7);
      chk("stall_stops", 32'({o_req0_stop, o_req1_stop}), 32'd3);
    end
    i_stop = 1'b0;
    cyc();
    chk("resume_data", 32'(o_data), 32'd8);
    // tie after idle gap with last=0 grants req1
    idle_in();
    do_reset();
    i_req0_valid = 1'b1; i_req0_data = DW'(11);
    cyc();
    idle_in();
    cyc();
    chk("gap_valid", 32'(o_valid), 32'd0);
    i_req0_valid = 1'b1; i_req1_valid = 1'b1; i_req0_data = DW'(12); i_req1_data = DW'(21);
    cyc();
    chk("gap_tie_src", 32'(o_src), 32'd1);
    // tie straight after reset grants req0
    do_reset();
    cyc();
    chk("rst_tie_src", 32'(o_src), 32'd0);
    // reset mid-burst discards beat and history
    cyc();
    do_reset();
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    cyc();
    chk("mid_rst_tie_src", 32'(o_src), 32'd0);
    // random traffic with scoreboard on per-source streams
    idle_in();
    do_reset();
    sent0.delete(); sent1.delete(); rx0.delete(); rx1.delete();
    n0 = 16'h1000; n1 = 16'h2000; c0 = 0; c1 = 0; bnd = 0;
    while ((c0 < 200 || c1 < 200) && bnd < 5000) begin
      i_req0_valid = (c0 < 200) && ($urandom_range(0, 9) < 6);
      i_req1_valid = (c1 < 200) && ($urandom_range(0, 9) < 6);
      i_stop = ($urandom_range(0, 2) == 0);
      i_req0_data = DW'(n0); i_req1_data = DW'(n1);
      cyc();
      if (acc_k == 0) begin n0++; c0++; end
      if (acc_k == 1) begin n1++; c1++; end
      bnd++;
    end
    chk("rand_bound", 32'(c0 >= 200 && c1 >= 200), 32'd1);
    idle_in();
    for (int i = 0; i < 3; i++) cyc();
    chk("rx0_len", 32'(rx0.size()), 32'(sent0.size()));
    chk("rx1_len", 32'(rx1.size()), 32'(sent1.size()));
    for (int i = 0; i < sent0.size() && i < rx0.size(); i++)
      chk("rx0_elem", 32'(rx0[i]), 32'(16'h1000 + i));
    for (int i = 0; i < sent1.size() && i < rx1.size(); i++)
      chk("rx1_elem", 32'(rx1[i]), 32'(16'h2000 + i));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
